// File: rtl/spi_flash_responder.sv
// SPI flash responder: a small read-only SPI NOR flash model (mode 0) backed by a
// host-writable byte RAM. Supports READ (0x03) with 24-bit address and streaming
// wrap-around, JEDEC ID (0x9F), and silently ignores every other command.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | deselected, or selected without a fresh flash_csn falling edge
// CMD    | shifting in the 8-bit command byte
// ADDR   | shifting in the 24-bit read address
// READ   | streaming memory bytes out on MISO, pointer auto-increments
// JEDEC  | streaming the 3-byte ID, then zero bytes
// IGNORE | unsupported command, discard until deselect
module spi_flash_responder #(
    parameter int          ADDR_BITS = 8,
    parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flash_clk,
    input  logic                 flash_csn,
    input  logic                 flash_io0_in,
    output logic                 flash_io1_out,
    output logic                 flash_io1_en,
    input  logic                 mem_we,
    input  logic [ADDR_BITS-1:0] mem_waddr,
    input  logic [7:0]           mem_wdata,
    output logic                 busy,
    output logic [7:0]           last_cmd
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    // Receive shifter must hold at least a command byte and a full read pointer.
    localparam int RXW = (ADDR_BITS > 8) ? ADDR_BITS : 8;
    localparam logic [ADDR_BITS-1:0] PTR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        READ,
        JEDEC,
        IGNORE
    } state_t;

    state_t               state, state_n;
    logic [4:0]           cnt, cnt_n;
    logic [RXW-2:0]       rx, rx_n;
    logic [RXW-1:0]       rx_shift;
    logic [7:0]           tx, tx_n;
    logic [ADDR_BITS-1:0] ptr, ptr_n;
    logic [7:0]           cmd_n;
    logic                 miso_q, miso_n;
    logic [1:0]           jcnt, jcnt_n;
    logic                 fetch;
    logic [ADDR_BITS-1:0] fetch_addr;
    logic                 load_q;
    logic [7:0]           rd_data;
    logic [7:0]           mem [0:DEPTH-1];

    logic sclk_s1, sclk_s2, sclk_s3;
    logic csn_s1, csn_s2, csn_s3;
    logic mosi_s1, mosi_s2;
    logic sclk_rise, sclk_fall, csn_rise, csn_fall;

    // Synchronize the SPI pins into clk. The chip-select chain resets to "selected"
    // so a still-low flash_csn after reset never looks like a new falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            csn_s1  <= 1'b0;
            csn_s2  <= 1'b0;
            csn_s3  <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            busy    <= 1'b0;
        end else begin
            sclk_s1 <= flash_clk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            csn_s1  <= flash_csn;
            csn_s2  <= csn_s1;
            csn_s3  <= csn_s2;
            mosi_s1 <= flash_io0_in;
            mosi_s2 <= mosi_s1;
            busy    <= ~csn_s2;
        end
    end

    // SPI clock edges only count while selected.
    assign sclk_rise = sclk_s2 & ~sclk_s3 & ~csn_s2;
    assign sclk_fall = ~sclk_s2 & sclk_s3 & ~csn_s2;
    assign csn_rise  = csn_s2 & ~csn_s3;
    assign csn_fall  = ~csn_s2 & csn_s3;
    assign rx_shift  = {rx, mosi_s2};

    // FSM and datapath register update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rx       <= '0;
            tx       <= '0;
            ptr      <= '0;
            last_cmd <= '0;
            miso_q   <= 1'b0;
            jcnt     <= '0;
            load_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rx       <= rx_n;
            tx       <= tx_n;
            ptr      <= ptr_n;
            last_cmd <= cmd_n;
            miso_q   <= miso_n;
            jcnt     <= jcnt_n;
            load_q   <= fetch;
        end
    end

    // Next-state and datapath decode. A fetched byte lands in tx one clk after the
    // fetch, well before the next detected falling edge at the supported SPI rate.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        rx_n       = rx;
        tx_n       = load_q ? rd_data : tx;
        ptr_n      = ptr;
        cmd_n      = last_cmd;
        miso_n     = miso_q;
        jcnt_n     = jcnt;
        fetch      = 1'b0;
        fetch_addr = ptr;
        if (csn_rise) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (csn_fall) begin
                        state_n = CMD;
                        cnt_n   = '0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        rx_n  = rx_shift[RXW-2:0];
                        cnt_n = cnt + 5'd1;
                        if (cnt == 5'd7) begin
                            cnt_n  = '0;
                            cmd_n  = rx_shift[7:0];
                            miso_n = 1'b0;
                            case (rx_shift[7:0])
                                8'h03: state_n = ADDR;
                                8'h9F: begin
                                    state_n = JEDEC;
                                    tx_n    = JEDEC_ID[23:16];
                                    jcnt_n  = 2'd1;
                                end
                                default: state_n = IGNORE;
                            endcase
                        end
                    end
                end
                ADDR: begin
                    if (sclk_rise) begin
                        rx_n  = rx_shift[RXW-2:0];
                        cnt_n = cnt + 5'd1;
                        if (cnt == 5'd23) begin
                            cnt_n      = '0;
                            ptr_n      = rx_shift[ADDR_BITS-1:0];
                            fetch      = 1'b1;
                            fetch_addr = rx_shift[ADDR_BITS-1:0];
                            miso_n     = 1'b0;
                            state_n    = READ;
                        end
                    end
                end
                READ: begin
                    if (sclk_fall) begin
                        miso_n = tx[7];
                        tx_n   = {tx[6:0], 1'b0};
                        cnt_n  = cnt + 5'd1;
                        if (cnt == 5'd7) begin
                            cnt_n      = '0;
                            ptr_n      = ptr + PTR_ONE;
                            fetch      = 1'b1;
                            fetch_addr = ptr + PTR_ONE;
                        end
                    end
                end
                JEDEC: begin
                    if (sclk_fall) begin
                        miso_n = tx[7];
                        tx_n   = {tx[6:0], 1'b0};
                        cnt_n  = cnt + 5'd1;
                        if (cnt == 5'd7) begin
                            cnt_n = '0;
                            case (jcnt)
                                2'd1:    tx_n = JEDEC_ID[15:8];
                                2'd2:    tx_n = JEDEC_ID[7:0];
                                default: tx_n = 8'h00;
                            endcase
                            if (jcnt != 2'd3) begin
                                jcnt_n = jcnt + 2'd1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Byte RAM: host writes and FSM fetches share the clock; a same-cycle
    // fetch of the written byte returns the previous contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (fetch) begin
            rd_data <= mem[fetch_addr];
        end
    end

    assign flash_io1_en  = ((state == READ) || (state == JEDEC)) && !csn_s2;
    assign flash_io1_out = flash_io1_en & miso_q;

endmodule
